set_assoc_cache: RTL
====================

# set_assoc_cache

Two-way set-associative, write-back, write-allocate cache with parametrised data width, address width and set count. It sits between a CPU-side load/store port and a slower backing memory, with a req/ack handshake on the memory side. It replaces the single-cycle direct-mapped cache with:
- miss handling,
- dirty-line eviction,
- per-set LRU replacement.

## Interface
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 8, word address width; one word per line.
- SETS, 8, number of sets; power of two, ≥2. IDX_W = log2(SETS), TAG_W = ADDR_WIDTH − IDX_W.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  request; accepted only when cpu_ready=1.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  word address; index = addr[IDX_W-1:0], tag = addr[ADDR_WIDTH-1:IDX_W].
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  high only in IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_done; 1 = hit.
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_done on reads; holds its value otherwise.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = fill.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_ack  in  1  one-cycle acknowledge; fill data on mem_rdata in the same cycle.
- mem_rdata  in  DATA_WIDTH  fill data.

## Operation
- Per way and set: valid, dirty and tag bits plus a data word. Per set: one lru bit naming the least-recently-used way.
- **IDLE**
  - cpu_ready=1.
  - cpu_req registers we/addr/wdata and moves to COMPARE.
- **COMPARE**
  - Hit (valid and tag equal in either way):
    - Read returns the data.
    - Write overwrites the data and sets dirty.
    - lru is set to the other way.
    - cpu_done pulses with cpu_hit=1; return to IDLE.
  - Miss, victim selection: invalid way first (way0 before way1), else way[lru].
  - Victim valid and dirty → WRITEBACK.
  - Otherwise, read miss → FILL; write miss → install directly (no fetch).
- **WRITEBACK**
  - mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - On mem_ack: read miss → FILL; write miss → install.
- **FILL**
  - mem_req=1, mem_we=0, mem_addr=request address.
  - On mem_ack: install mem_rdata with dirty=0, and cpu_rdata=mem_rdata.
- **Install**
  - Write victim way with valid=1 and the request tag.
  - Write miss: data=cpu_wdata, dirty=1.
  - lru is set to the other way.
  - cpu_done pulses with cpu_hit=0; return to IDLE.
- **Ignored inputs**
  - mem_ack is ignored while mem_req=0.
  - cpu_req is ignored while cpu_ready=0; the request is not queued.

## Timing
- All outputs are registered.
- Reset values:
  - cpu_ready=1.
  - cpu_done, cpu_hit, mem_req and mem_we are 0.
  - cpu_rdata, mem_addr and mem_wdata are 0.
  - All valid, dirty and lru bits cleared; state IDLE.
- Request accepted at edge N:
  - Hit: cpu_done is high in cycle N+2, with cpu_ready=1 in the same cycle. Back-to-back hits therefore complete every 2 cycles.
  - Miss: mem_req rises in cycle N+2. cpu_done is high in the cycle after the final mem_ack.
  - Dirty miss: writeback mem_ack, then mem_req deasserts for one cycle, then the fill request starts.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req falls in the cycle after mem_ack.
- Reset mid-miss aborts the transaction: mem_req=0 in the cycle after rst is sampled, no cpu_done, contents invalidated.

## Structure
- Package cache_pkg holds:
  - state enum: IDLE, COMPARE, WRITEBACK, FILL;
  - WAYS=2 localparam;
  - IDX_W/TAG_W width functions.
- Sub-module cache_tag_store holds:
  - valid, dirty, tag and lru arrays;
  - per-way hit compare, hit_way, and victim selection.
- The top level holds the FSM, the data arrays and the handshake registers.

## Test plan
Configuration: SETS=8, DATA_WIDTH=32.
1. After reset, read 0x13:
   - mem_req=1, mem_we=0, mem_addr=0x13;
   - ack 3 cycles later with mem_rdata=0xDEADBEEF → cpu_done, cpu_hit=0, cpu_rdata=0xDEADBEEF;
   - re-read 0x13 → cpu_done 2 cycles after accept, cpu_hit=1, cpu_rdata=0xDEADBEEF.
2. Write 0x23 with 0x11111111 (clean miss) → no mem_req, cpu_done with cpu_hit=0; read 0x23 → cpu_hit=1, cpu_rdata=0x11111111.
3. Continuing from 2, read 0x13 (hit), then read 0x33:
   - victim is 0x23's way (LRU, dirty) → writeback mem_we=1, mem_addr=0x23, mem_wdata=0x11111111;
   - then fill at mem_addr=0x33;
   - read 0x13 still hits.
4. Write hit 0x13 with 0xA5A5A5A5 → no mem traffic. Read 0x33, then read 0x43 → writeback mem_addr=0x13, mem_wdata=0xA5A5A5A5.
5. Assert rst while in FILL awaiting mem_ack → mem_req=0 next cycle, no cpu_done; subsequent read 0x13 misses.
6. cpu_req held during a miss → no second acceptance; mem_ack pulsed while mem_req=0 → no state change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the two-way set-associative cache.
//   state_t        : controller states (IDLE, COMPARE, WRITEBACK, FILL)
//   WAYS           : associativity (fixed at two; one lru bit per set)
//   cache_idx_w()  : set-index width for a given set count
//   cache_tag_w()  : tag width for a given word-address width and set count
package cache_pkg;

  localparam int WAYS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  function automatic int cache_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int cache_tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/state store for the two-way cache: valid, dirty and tag per way and
// set, plus one lru bit per set naming the least-recently-used way.
// Lookup is combinational on idx/tag; updates happen on the clock edge.
//   clk, rst      : clock, synchronous active-high reset (clears valid,
//                   dirty and lru; tags are left as-is)
//   idx, tag      : set index and tag of the request being looked up
//   hit, hit_way  : lookup result (hit_way only meaningful when hit=1)
//   victim_*      : replacement candidate for the set and its state
//   wr_*          : install/mark a line: valid=1, tag=wr_tag, dirty=wr_dirty
//   lru_en/lru_way: record an access to lru_way (lru becomes the other way)
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic             hit_way,
  output logic             victim_way,
  output logic             victim_valid,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             wr_en,
  input  logic             wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_dirty,
  input  logic             lru_en,
  input  logic             lru_way
);

  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  dirty_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [SETS-1:0]  lru_q;

  logic hit0;
  logic hit1;

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit0 ? 1'b0 : 1'b1;

  // Fill empty ways before evicting anything; way0 is preferred.
  always_comb begin
    victim_way = lru_q[idx];
    if (!valid_q[0][idx]) begin
      victim_way = 1'b0;
    end else if (!valid_q[1][idx]) begin
      victim_way = 1'b1;
    end
  end

  assign victim_valid = valid_q[victim_way][idx];
  assign victim_dirty = dirty_q[victim_way][idx];
  assign victim_tag   = tag_q[victim_way][idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_way][idx] <= 1'b1;
        dirty_q[wr_way][idx] <= wr_dirty;
      end
      if (lru_en) begin
        lru_q[idx] <= ~lru_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Two-way set-associative, write-back, write-allocate cache with one word
// per line and per-set LRU replacement. A CPU request is captured in IDLE,
// looked up in COMPARE, and on a miss may go through WRITEBACK (dirty
// victim) and FILL (read miss) over a req/ack memory handshake.
//   clk, rst               : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  : CPU request, taken only while cpu_ready=1
//   cpu_ready              : high only in IDLE
//   cpu_done/hit/rdata     : one-cycle completion pulse, hit flag, read data
//   mem_req/we/addr/wdata  : memory request, held until mem_ack
//   mem_ack/rdata          : one-cycle acknowledge with fill data
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int SETS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic                  cpu_hit,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int IDX_W = cache_idx_w(SETS);
  localparam int TAG_W = cache_tag_w(ADDR_WIDTH, SETS);

  state_t state;

  logic                  req_we_p0;
  logic [ADDR_WIDTH-1:0] req_addr_p0;
  logic [DATA_WIDTH-1:0] req_wdata_p0;
  logic                  vic_way_p0;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx = req_addr_p0[IDX_W-1:0];
  assign tag = req_addr_p0[ADDR_WIDTH-1:IDX_W];

  logic             hit;
  logic             hit_way;
  logic             victim_way;
  logic             victim_valid;
  logic             victim_dirty;
  logic [TAG_W-1:0] victim_tag;

  logic             wr_en;
  logic             wr_way;
  logic             wr_dirty;
  logic             lru_en;
  logic             lru_way;

  logic                  data_we;
  logic                  data_way;
  logic [DATA_WIDTH-1:0] data_wval;
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS];

  cache_tag_store #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tag_store (
    .clk          (clk),
    .rst          (rst),
    .idx          (idx),
    .tag          (tag),
    .hit          (hit),
    .hit_way      (hit_way),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .wr_en        (wr_en),
    .wr_way       (wr_way),
    .wr_tag       (tag),
    .wr_dirty     (wr_dirty),
    .lru_en       (lru_en),
    .lru_way      (lru_way)
  );

  // Array update strobes. Every install or hit also marks the touched way
  // as most-recently-used. After COMPARE the victim way comes from the
  // register captured there, since the set is not touched in between.
  always_comb begin
    wr_en     = 1'b0;
    wr_way    = 1'b0;
    wr_dirty  = 1'b0;
    lru_en    = 1'b0;
    lru_way   = 1'b0;
    data_we   = 1'b0;
    data_way  = 1'b0;
    data_wval = req_wdata_p0;
    case (state)
      COMPARE: begin
        if (hit) begin
          lru_en  = 1'b1;
          lru_way = hit_way;
          if (req_we_p0) begin
            wr_en    = 1'b1;
            wr_way   = hit_way;
            wr_dirty = 1'b1;
            data_we  = 1'b1;
            data_way = hit_way;
          end
        end else if (req_we_p0 && !(victim_valid && victim_dirty)) begin
          // Write miss with a clean victim installs without any fetch.
          wr_en    = 1'b1;
          wr_way   = victim_way;
          wr_dirty = 1'b1;
          lru_en   = 1'b1;
          lru_way  = victim_way;
          data_we  = 1'b1;
          data_way = victim_way;
        end
      end
      WRITEBACK: begin
        if (mem_req && mem_ack && req_we_p0) begin
          wr_en    = 1'b1;
          wr_way   = vic_way_p0;
          wr_dirty = 1'b1;
          lru_en   = 1'b1;
          lru_way  = vic_way_p0;
          data_we  = 1'b1;
          data_way = vic_way_p0;
        end
      end
      FILL: begin
        if (mem_req && mem_ack) begin
          wr_en     = 1'b1;
          wr_way    = vic_way_p0;
          wr_dirty  = 1'b0;
          lru_en    = 1'b1;
          lru_way   = vic_way_p0;
          data_we   = 1'b1;
          data_way  = vic_way_p0;
          data_wval = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_way][idx] <= data_wval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_ready  <= 1'b1;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vic_way_p0 <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        // p0 boundary: request captured here, looked up next cycle
        IDLE: begin
          if (cpu_req) begin
            req_we_p0    <= cpu_we;
            req_addr_p0  <= cpu_addr;
            req_wdata_p0 <= cpu_wdata;
            cpu_ready    <= 1'b0;
            state        <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (!req_we_p0) begin
              cpu_rdata <= data_mem[hit_way][idx];
            end
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            vic_way_p0 <= victim_way;
            if (victim_valid && victim_dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {victim_tag, idx};
              mem_wdata <= data_mem[victim_way][idx];
              state     <= WRITEBACK;
            end else if (!req_we_p0) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= req_addr_p0;
              state    <= FILL;
            end else begin
              cpu_done  <= 1'b1;
              cpu_hit   <= 1'b0;
              cpu_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        WRITEBACK: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            if (req_we_p0) begin
              cpu_done  <= 1'b1;
              cpu_hit   <= 1'b0;
              cpu_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          // Entered with mem_req low after a writeback: issue the fill now,
          // leaving the one idle cycle between the two transfers.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr_p0;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= mem_rdata;
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
